// File: rtl/crc_lut_gen.sv
// CRC lookup-table generator: builds a 256-entry reflected CRC table in
// internal storage, one byte-step per clock, then serves registered reads.
// SLICE > 0 folds trailing zero bytes into each entry for slicing-by-N use.
module crc_lut_gen #(
  parameter int          CRC_W = 32,
  parameter logic [63:0] POLY  = 64'h0000_0000_EDB8_8320,
  parameter int          SLICE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CRC_W-1:0] poly_i,
  input  logic             regen_i,
  input  logic             rd_en_i,
  input  logic [7:0]       addr_i,
  output logic [CRC_W-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             rd_err_o,
  output logic             busy_o,
  output logic             ready_o
);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'(SLICE);

  state_t           state_q;
  state_t           state_d;
  logic [CRC_W-1:0] mem [256];
  logic [CRC_W-1:0] poly_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_nxt;
  logic [7:0]       idx_q;
  logic [3:0]       step_q;
  logic             last_step;
  logic             gen_we;

  // Eight unrolled reflected bit-steps: one full byte of CRC processing.
  function automatic logic [CRC_W-1:0] byte_step(input logic [CRC_W-1:0] crc_in,
                                                 input logic [CRC_W-1:0] poly);
    logic [CRC_W-1:0] c;
    c = crc_in;
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_nxt   = byte_step(crc_q, poly_q);
  assign last_step = (step_q == LAST_STEP);
  assign gen_we    = (state_q == INIT) && last_step;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Next state: leave INIT on the write of the last entry, re-enter on regen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (gen_we && (idx_q == 8'hFF)) state_d = READY;
      READY:   if (regen_i) state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy_o  = 1'b1;
    ready_o = 1'b0;
    if (state_q == READY) begin
      busy_o  = 1'b0;
      ready_o = 1'b1;
    end
  end

  // Generator control: index, byte-step count, work register, polynomial.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poly_q <= POLY[CRC_W-1:0];
      idx_q  <= 8'd0;
      step_q <= 4'd0;
      crc_q  <= '0;
    end else if (state_q == READY) begin
      if (regen_i) begin
        poly_q <= poly_i;
        idx_q  <= 8'd0;
        step_q <= 4'd0;
        crc_q  <= '0;
      end
    end else if (last_step) begin
      // Entry finished this cycle; seed the work register with the next index.
      idx_q  <= idx_q + 8'd1;
      step_q <= 4'd0;
      crc_q  <= CRC_W'(8'(idx_q + 8'd1));
    end else begin
      crc_q  <= crc_nxt;
      step_q <= step_q + 4'd1;
    end
  end

  // Table storage, written only by the generator on an entry's final byte-step.
  always_ff @(posedge clk) begin
    if (gen_we) mem[idx_q] <= crc_nxt;
  end

  // Read port: registered data in READY, error pulse while the table is rebuilding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      rd_err_o <= 1'b0;
    end else begin
      rvalid_o <= rd_en_i && (state_q == READY);
      rd_err_o <= rd_en_i && (state_q == INIT);
      if (rd_en_i && (state_q == READY)) rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: tb/tb_crc_lut_gen.sv
// Directed bench for crc_lut_gen: one default instance (SLICE=0) and one
// SLICE=1 instance sharing clock and reset.
module tb_crc_lut_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] poly0 = 32'h0;
  logic        regen0 = 1'b0;
  logic        rd_en0 = 1'b0;
  logic [7:0]  addr0 = 8'h0;
  logic [31:0] rdata0;
  logic        rvalid0, rd_err0, busy0, ready0;

  logic [31:0] poly1 = 32'h0;
  logic        regen1 = 1'b0;
  logic        rd_en1 = 1'b0;
  logic [7:0]  addr1 = 8'h0;
  logic [31:0] rdata1;
  logic        rvalid1, rd_err1, busy1, ready1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc_lut_gen #(.CRC_W(32), .SLICE(0)) u_s0 (
    .clk(clk), .rst(rst), .poly_i(poly0), .regen_i(regen0), .rd_en_i(rd_en0),
    .addr_i(addr0), .rdata_o(rdata0), .rvalid_o(rvalid0), .rd_err_o(rd_err0),
    .busy_o(busy0), .ready_o(ready0)
  );

  crc_lut_gen #(.CRC_W(32), .SLICE(1)) u_s1 (
    .clk(clk), .rst(rst), .poly_i(poly1), .regen_i(regen1), .rd_en_i(rd_en1),
    .addr_i(addr1), .rdata_o(rdata1), .rvalid_o(rvalid1), .rd_err_o(rd_err1),
    .busy_o(busy1), .ready_o(ready1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte-serial reflected CRC (init 0, no final xor) of byte k then one zero byte.
  function automatic logic [31:0] gold_s1(input int k);
    logic [31:0] c;
    logic [7:0]  msg [2];
    msg[0] = 8'(k);
    msg[1] = 8'h00;
    c = 32'h0;
    for (int m = 0; m < 2; m++) begin
      c = c ^ {24'h0, msg[m]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic read0(input logic [7:0] a, input logic [31:0] exp, input string tag);
    rd_en0 = 1'b1;
    addr0  = a;
    tick();
    check({tag, "_rvalid"}, {63'h0, rvalid0}, 64'h1);
    check({tag, "_data"}, {32'h0, rdata0}, {32'h0, exp});
  endtask

  task automatic wait_ready0(input int start, output int cyc);
    cyc = start;
    while (!ready0 && cyc < 2000) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int c;
    int r0;
    int r1;

    // Reset state
    tick();
    tick();
    check("rst_rdata", {32'h0, rdata0}, 64'h0);
    check("rst_rvalid", {63'h0, rvalid0}, 64'h0);
    check("rst_rd_err", {63'h0, rd_err0}, 64'h0);
    check("rst_busy", {63'h0, busy0}, 64'h1);
    check("rst_ready", {63'h0, ready0}, 64'h0);

    // Initial generation: measure INIT length of both instances
    rst = 1'b0;
    c = 0; r0 = -1; r1 = -1;
    while ((r0 < 0 || r1 < 0) && c < 2000) begin
      tick();
      c++;
      if (r0 < 0 && ready0) r0 = c;
      if (r1 < 0 && ready1) r1 = c;
    end
    check("s0_init_cycles", 64'(r0), 64'd256);
    check("s1_init_cycles", 64'(r1), 64'd512);
    check("s0_ready_not_busy", {63'h0, busy0}, 64'h0);

    // Back-to-back reads from the default table
    read0(8'h00, 32'h00000000, "rd00");
    read0(8'h01, 32'h77073096, "rd01");
    read0(8'h02, 32'hEE0E612C, "rd02");
    read0(8'h80, 32'hEDB88320, "rd80");
    read0(8'hFF, 32'h2D02EF8D, "rdFF");
    rd_en0 = 1'b0;
    tick();
    check("idle_rvalid", {63'h0, rvalid0}, 64'h0);
    check("idle_hold", {32'h0, rdata0}, 64'h2D02EF8D);

    // SLICE=1 table against the golden model
    for (int k = 0; k < 256; k++) begin
      rd_en1 = 1'b1;
      addr1  = 8'(k);
      tick();
      check($sformatf("s1_entry_%0d", k), {31'h0, rvalid1, rdata1}, {31'h0, 1'b1, gold_s1(k)});
    end
    rd_en1 = 1'b0;

    // Read and regen together: read served from old table, rebuild starts
    rd_en0 = 1'b1;
    addr0  = 8'h80;
    regen0 = 1'b1;
    poly0  = 32'h82F63B78;
    tick();
    regen0 = 1'b0;
    check("regen_rd_rvalid", {63'h0, rvalid0}, 64'h1);
    check("regen_rd_data", {32'h0, rdata0}, 64'hEDB88320);
    check("regen_busy", {63'h0, busy0}, 64'h1);

    // Read during INIT is rejected
    addr0 = 8'h01;
    tick();
    rd_en0 = 1'b0;
    check("init_rd_err", {63'h0, rd_err0}, 64'h1);
    check("init_rd_rvalid", {63'h0, rvalid0}, 64'h0);
    check("init_rd_hold", {32'h0, rdata0}, 64'hEDB88320);
    tick();
    check("init_rd_err_pulse", {63'h0, rd_err0}, 64'h0);

    // Regen mid-INIT with another polynomial must be ignored
    c = 2;
    while (!ready0 && c < 2000) begin
      if (c == 50) begin
        regen0 = 1'b1;
        poly0  = 32'h12345678;
      end else begin
        regen0 = 1'b0;
      end
      tick();
      c++;
    end
    regen0 = 1'b0;
    check("crc32c_init_cycles", 64'(c), 64'd256);
    read0(8'h01, 32'hF26B8303, "c_rd01");
    read0(8'h80, 32'h82F63B78, "c_rd80");
    rd_en0 = 1'b0;
    tick();

    // Reset mid-INIT discards the runtime polynomial
    regen0 = 1'b1;
    poly0  = 32'h82F63B78;
    tick();
    regen0 = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'h0, busy0}, 64'h1);
    check("midrst_ready", {63'h0, ready0}, 64'h0);
    check("midrst_rdata", {32'h0, rdata0}, 64'h0);
    tick();
    rst = 1'b0;
    wait_ready0(0, c);
    check("rebuild_cycles", 64'(c), 64'd256);
    read0(8'h01, 32'h77073096, "r_rd01");
    read0(8'hFF, 32'h2D02EF8D, "r_rdFF");
    rd_en0 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
